// File: rtl/alu_seq_pkg.sv
// Shared definitions for the byte-serial add/subtract unit.
package alu_seq_pkg;

  localparam int BYTE_W = 8;

  // Sequencer states; encoding is fixed so it can be decoded elsewhere.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_seq8_add8.sv
// 8-bit carry-lookahead slice: two 4-bit lookahead groups with a group-level
// carry skip, so the carry out never ripples through individual bits.
module add8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_1,
  output logic [7:0] s,
  output logic       c7
);

  logic [7:0] g, p, c;
  logic [1:0] gg, gp;

  // Bit generate/propagate, in-group carries and group carry-out.
  always_comb begin
    g = a & b;
    p = a ^ b;
    c = '0;

    c[0] = c_1;
    c[1] = g[0] | (p[0] & c_1);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_1);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_1);
    gg[0] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    gp[0] = &p[3:0];

    c[4] = gg[0] | (gp[0] & c_1);
    c[5] = g[4] | (p[4] & c[4]);
    c[6] = g[5] | (p[5] & g[4]) | (p[5] & p[4] & c[4]);
    c[7] = g[6] | (p[6] & g[5]) | (p[6] & p[5] & g[4]) | (p[6] & p[5] & p[4] & c[4]);
    gg[1] = g[7] | (p[7] & g[6]) | (p[7] & p[6] & g[5]) | (p[7] & p[6] & p[5] & g[4]);
    gp[1] = &p[7:4];

    s  = p ^ c;
    c7 = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_1);
  end

endmodule

// File: rtl/add_seq8.sv
// Byte-serial WIDTH-bit add/subtract: one add8 slice, LSB byte first,
// inter-byte carry held in a flop. Valid/ready on both sides, no overlap
// between an op in flight and the next accept.
module add_seq8
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             busy
);

  localparam int NB = WIDTH / BYTE_W;
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  state_t            state, state_nx;
  logic [WIDTH-1:0]  a_r, b_r;
  logic              carry, zacc;
  logic [IW-1:0]     idx;
  logic [BYTE_W-1:0] sa, sb, s;
  logic              c7;
  logic              accept, last;

  add8 u_add8 (
    .a   (sa),
    .b   (sb),
    .c_1 (carry),
    .s   (s),
    .c7  (c7)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    accept    = 1'b0;
    last      = (idx == LAST);
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nx = RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Byte select feeding the slice.
  always_comb begin
    sa = '0;
    sb = '0;
    for (int i = 0; i < NB; i++) begin
      if (idx == IW'(i)) begin
        sa = a_r[i*BYTE_W +: BYTE_W];
        sb = b_r[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Operand capture, per-byte result write-back and final flags.
  // b is stored pre-inverted for subtract so the slice only ever adds; the
  // initial carry of 1 completes the two's complement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      zacc  <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (accept) begin
      a_r   <= a;
      b_r   <= b ^ {WIDTH{sub}};
      carry <= sub;
      zacc  <= 1'b1;
      idx   <= '0;
    end else if (state == RUN) begin
      for (int i = 0; i < NB; i++)
        if (idx == IW'(i)) sum[i*BYTE_W +: BYTE_W] <= s;
      carry <= c7;
      zacc  <= zacc & (s == '0);
      // Hold on the last byte so idx never leaves 0..NB-1 for non-power-of-2 NB.
      idx   <= last ? idx : idx + IW'(1);
      if (last) begin
        cout <= c7;
        zero <= zacc & (s == '0);
        ovf  <= (a_r[WIDTH-1] == b_r[WIDTH-1]) & (s[BYTE_W-1] != a_r[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_add_seq8.sv
// Scoreboard bench for add_seq8 (WIDTH=32): directed corner cases, timing,
// backpressure, async reset mid-op, then random ops with handshake gaps.
module tb_add_seq8;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, cout, ovf, zero, busy;
  logic [W-1:0] sum;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  res_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  add_seq8 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W:0] t;
    res_t r;
    if (s) t = {1'b0, x} + {1'b0, ~y} + (W+1)'(1);
    else   t = {1'b0, x} + {1'b0, y};
    r.sum  = t[W-1:0];
    r.cout = t[W];
    if (s) r.ovf = (x[W-1] != y[W-1]) && (r.sum[W-1] != x[W-1]);
    else   r.ovf = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Scoreboard: push on accept, pop and compare on output handshake.
  always @(negedge clk) begin : mon
    res_t e;
    if (!rst) begin
      if (out_valid && out_ready) begin
        chk("sb_pop", q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("sum",  sum,  e.sum);
          chk("cout", cout, e.cout);
          chk("ovf",  ovf,  e.ovf);
          chk("zero", zero, e.zero);
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, sub));
    end
  end

  // Called #1 after an edge; returns #1 after the accept edge.
  task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic ts);
    int n;
    n = 0;
    a = ta; b = tb2; sub = ts; in_valid = 1'b1;
    while (!in_ready && n < 64) begin @(posedge clk); #1; n++; end
    chk("accept_to", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 64) begin @(posedge clk); #1; cyc++; end
    chk("done_to", out_valid, 1);
  endtask

  task automatic take(input int dly);
    repeat (dly) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int cyc;
    logic [W-1:0] s0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum",       sum,       0);
    chk("rst_cout",      cout,      0);
    chk("rst_ovf",       ovf,       0);
    chk("rst_zero",      zero,      0);
    chk("rst_busy",      busy,      0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: latency and simple carry across a byte boundary
    drive(32'h0000_00FF, 32'h1, 1'b0);
    wait_done(cyc);
    chk("t1_latency", cyc, 4);
    chk("t1_sum",  sum,  32'h0000_0100);
    chk("t1_cout", cout, 0);
    chk("t1_ovf",  ovf,  0);
    chk("t1_zero", zero, 0);
    take(0);

    // 2: carry ripples through every byte
    drive(32'hFFFF_FFFF, 32'h1, 1'b0);
    wait_done(cyc);
    chk("t2_sum",  sum,  0);
    chk("t2_cout", cout, 1);
    chk("t2_zero", zero, 1);
    chk("t2_ovf",  ovf,  0);
    take(1);

    // 3: signed overflow on add
    drive(32'h7FFF_FFFF, 32'h1, 1'b0);
    wait_done(cyc);
    chk("t3_sum",  sum,  32'h8000_0000);
    chk("t3_ovf",  ovf,  1);
    chk("t3_cout", cout, 0);
    take(0);

    // 4: subtract with borrow, then subtract with signed overflow
    drive(32'd5, 32'd7, 1'b1);
    wait_done(cyc);
    chk("t4a_sum",  sum,  32'hFFFF_FFFE);
    chk("t4a_cout", cout, 0);
    chk("t4a_ovf",  ovf,  0);
    take(0);
    drive(32'h8000_0000, 32'h1, 1'b1);
    wait_done(cyc);
    chk("t4b_sum",  sum,  32'h7FFF_FFFF);
    chk("t4b_ovf",  ovf,  1);
    chk("t4b_cout", cout, 1);
    take(0);

    // 5: backpressure with in_valid held high throughout
    a = 32'h1234_5678; b = 32'h1111_1111; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    wait_done(cyc);
    s0 = sum;
    chk("t5_sum", s0, 32'h2345_6789);
    repeat (5) begin
      @(posedge clk); #1;
      chk("t5_in_ready",  in_ready,  0);
      chk("t5_out_valid", out_valid, 1);
      chk("t5_stable",    sum,       s0);
      chk("t5_qdepth",    q.size(),  1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("t5_drop_valid", out_valid, 0);
    chk("t5_idle_ready", in_ready,  1);
    chk("t5_qempty",     q.size(),  0);
    @(posedge clk); #1;
    chk("t5_second_acc", q.size(), 1);
    in_valid = 1'b0;
    wait_done(cyc);
    take(0);

    // 6: async reset mid-RUN (idx=2), then recovery
    drive(32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready",  in_ready,  1);
    chk("t6_sum",       sum,       0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    drive(32'h0000_00FF, 32'h1, 1'b0);
    wait_done(cyc);
    chk("t6_lat", cyc, 4);
    chk("t6_res", sum, 32'h0000_0100);
    take(0);

    // Random ops with idle gaps, early out_ready pulses and output stalls
    for (int i = 0; i < 3000; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      drive(pick(), pick(), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
      end
      wait_done(cyc);
      take($urandom_range(0, 2));
    end

    chk("final_qempty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
